// File: rtl/simple_dma_controller_pkg.sv
// Shared definitions for the simple DMA controller: FSM encoding, transfer
// direction constants and byte-enable patterns.
package simple_dma_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_DEV = 3'd1,
    ST_BUS      = 3'd2,
    ST_RDATA    = 3'd3,
    ST_ACK      = 3'd4,
    ST_GUARD    = 3'd5,
    ST_DONE     = 3'd6
  } dma_state_e;

  localparam logic DMA_RD = 1'b1;
  localparam logic DMA_WR = 1'b0;

  localparam logic [1:0] WE_WORD = 2'b11;
  localparam logic [1:0] WE_NONE = 2'b00;

endpackage

// File: rtl/simple_dma_controller.sv
// Word-granular DMA engine between a request/ack device and the openMSP430 DMA port.
// One transfer context; reads go memory->dev_in, writes go dev_out->memory.
module simple_dma_controller
  import simple_dma_controller_pkg::*;
#(
  parameter logic DMA_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_rqst,
  input  logic        dma_rd_wr,
  input  logic [15:0] dma_start_address,
  input  logic [15:0] dma_num_words,
  input  logic        dev_ack,
  input  logic [15:0] dev_out,
  output logic [15:0] dev_in,
  output logic        dma_ack,
  output logic        dma_end_flag,
  output logic        dma_err,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic        dma_priority,
  input  logic [15:0] dma_dout,
  input  logic        dma_ready,
  input  logic        dma_resp,
  output logic [2:0]  dbg_state
);

  dma_state_e  state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        rd_wr_q, rd_wr_d;
  logic        dev_pend_q, dev_pend_d;
  logic [15:0] din_q, din_d;
  logic [15:0] dev_in_q, dev_in_d;

  // Word addressing: the byte-address LSB carries no information.
  logic start_lsb_unused;
  assign start_lsb_unused = dma_start_address[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_wr_q    <= 1'b0;
      dev_pend_q <= 1'b0;
      din_q      <= '0;
      dev_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_wr_q    <= rd_wr_d;
      dev_pend_q <= dev_pend_d;
      din_q      <= din_d;
      dev_in_q   <= dev_in_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rd_wr_d  = rd_wr_q;
    din_d    = din_q;
    dev_in_d = dev_in_q;
    // ACK/GUARD ignore dev_ack so a level ack left over from the previous word is not re-counted.
    dev_pend_d = dev_pend_q |
                 (dev_ack && (state_q != ST_ACK) && (state_q != ST_GUARD));
    case (state_q)
      ST_IDLE: begin
        if (dma_rqst) begin
          addr_d  = dma_start_address[15:1];
          cnt_d   = dma_num_words;
          err_d   = 1'b0;
          rd_wr_d = dma_rd_wr;
          state_d = (dma_num_words == 16'd0) ? ST_DONE : ST_WAIT_DEV;
        end
      end
      ST_WAIT_DEV: begin
        if (!dma_rqst) begin
          state_d = ST_IDLE;
        end else if (dev_pend_q || dev_ack) begin
          din_d      = dev_out;
          dev_pend_d = 1'b0;
          state_d    = ST_BUS;
        end
      end
      ST_BUS: begin
        // The core owns the access until it answers, so dma_rqst is not looked at here.
        if (dma_ready) begin
          if (dma_resp) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = (rd_wr_q == DMA_RD) ? ST_RDATA : ST_ACK;
          end
        end
      end
      ST_RDATA: begin
        dev_in_d = dma_dout;
        state_d  = ST_ACK;
      end
      ST_ACK: begin
        addr_d  = addr_q + 15'd1;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? ST_DONE : ST_GUARD;
      end
      ST_GUARD: begin
        state_d = dma_rqst ? ST_WAIT_DEV : ST_IDLE;
      end
      ST_DONE: begin
        if (!dma_rqst) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dma_en       = (state_q == ST_BUS);
  assign dma_addr     = dma_en ? addr_q : '0;
  assign dma_din      = (dma_en && (rd_wr_q == DMA_WR)) ? din_q : '0;
  assign dma_we       = (dma_en && (rd_wr_q == DMA_WR)) ? WE_WORD : WE_NONE;
  assign dma_ack      = (state_q == ST_ACK);
  assign dma_end_flag = (state_q == ST_DONE);
  assign dma_err      = err_q;
  assign dev_in       = dev_in_q;
  assign dma_priority = DMA_PRIORITY;
  assign dbg_state    = state_q;

endmodule
